// File: rtl/imm_decode_ctrl_if.sv
// Fetch-side and issue-side handshake bundle for the immediate-decode sequencer.
// slave is the sequencer's view; master is the surrounding pipeline's view.
interface imm_decode_ctrl_if #(
    parameter int unsigned PC_WIDTH = 32
);
    logic                IN_VALID;
    logic                IN_READY;
    logic [31:0]         INSTRUCTION;
    logic [PC_WIDTH-1:0] PC;
    logic                OUT_VALID;
    logic                OUT_READY;
    logic [31:0]         OUT_INSTRUCTION;
    logic [PC_WIDTH-1:0] OUT_PC;
    logic [3:0]          IMM_SEL;
    logic                IMM_EN;
    logic                ILLEGAL;

    modport slave (
        input  IN_VALID, INSTRUCTION, PC, OUT_READY,
        output IN_READY, OUT_VALID, OUT_INSTRUCTION, OUT_PC, IMM_SEL, IMM_EN, ILLEGAL
    );

    modport master (
        output IN_VALID, INSTRUCTION, PC, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_INSTRUCTION, OUT_PC, IMM_SEL, IMM_EN, ILLEGAL
    );
endinterface

// File: rtl/imm_decode_ctrl.sv
// Decode-stage sequencer: decodes opcode/funct3 into an immediate-select code and holds
// results in a head + skid pair so downstream back-pressure never drops a fetch.
module imm_decode_ctrl #(
    parameter int unsigned PC_WIDTH      = 32,
    parameter logic [6:0]  CUSTOM_OPCODE = 7'b0001011
) (
    input logic              CLK,
    input logic              RESET,
    input logic              FLUSH,
    imm_decode_ctrl_if.slave bus
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    typedef struct packed {
        logic [31:0]         instr;
        logic [PC_WIDTH-1:0] pc;
        logic [3:0]          sel;
        logic                en;
        logic                ill;
    } entry_t;

    state_e state_q, state_d;
    logic   in_ready_q, in_ready_d;
    logic   out_valid_q, out_valid_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;
    logic   accept, pop;

    logic [6:0] opcode;
    logic [2:0] funct3;

    assign opcode = bus.INSTRUCTION[6:0];
    assign funct3 = bus.INSTRUCTION[14:12];

    always_comb begin
        in_entry.instr = bus.INSTRUCTION;
        in_entry.pc    = bus.PC;
        in_entry.sel   = 4'b0000;
        in_entry.en    = 1'b0;
        in_entry.ill   = 1'b0;
        case (opcode)
            7'b0110111, 7'b0010111: in_entry.en = 1'b1;
            7'b1101111: begin
                in_entry.sel = 4'b0001;
                in_entry.en  = 1'b1;
            end
            7'b1100111, 7'b0000011: begin
                in_entry.sel = 4'b0010;
                in_entry.en  = 1'b1;
            end
            7'b0010011: begin
                // Shift-immediates carry a shamt field instead of a full I-immediate.
                in_entry.sel = (funct3 == 3'b001 || funct3 == 3'b101) ? 4'b0101 : 4'b0010;
                in_entry.en  = 1'b1;
            end
            7'b1100011: begin
                in_entry.sel = 4'b0011;
                in_entry.en  = 1'b1;
            end
            7'b0100011: begin
                in_entry.sel = 4'b0100;
                in_entry.en  = 1'b1;
            end
            7'b0110011, 7'b0001111, 7'b1110011: ;
            default: begin
                if (opcode == CUSTOM_OPCODE) begin
                    in_entry.sel = 4'b1010;
                    in_entry.en  = 1'b1;
                end else begin
                    in_entry.ill = 1'b1;
                end
            end
        endcase
    end

    assign accept = bus.IN_VALID & in_ready_q;
    assign pop    = out_valid_q & bus.OUT_READY;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (FLUSH) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        head_d  = in_entry;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (accept && pop) begin
                        head_d = in_entry;
                    end else if (accept) begin
                        skid_d  = in_entry;
                        state_d = StFull;
                    end else if (pop) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (pop) begin
                        head_d  = skid_q;
                        state_d = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
        in_ready_d  = (state_d != StFull);
        out_valid_d = (state_d != StEmpty);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= StEmpty;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Payload needs no reset: every output field is masked by out_valid_q.
    always_ff @(posedge CLK) begin
        head_q <= head_d;
        skid_q <= skid_d;
    end

    assign bus.IN_READY        = in_ready_q;
    assign bus.OUT_VALID       = out_valid_q;
    assign bus.OUT_INSTRUCTION = out_valid_q ? head_q.instr : '0;
    assign bus.OUT_PC          = out_valid_q ? head_q.pc    : '0;
    assign bus.IMM_SEL         = out_valid_q ? head_q.sel   : 4'b0000;
    assign bus.IMM_EN          = out_valid_q & head_q.en;
    assign bus.ILLEGAL         = out_valid_q & head_q.ill;

endmodule

// File: tb/tb_imm_decode_ctrl.sv
// Self-checking bench for imm_decode_ctrl: directed scenarios plus a randomised
// handshake run checked against a FIFO scoreboard.
module tb_imm_decode_ctrl;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [3:0]  sel;
        logic        en;
        logic        ill;
    } item_t;

    localparam int N = 12;

    logic CLK;
    logic RESET;
    logic FLUSH;
    int   checks;
    int   errors;

    item_t       exp_q[$];
    logic [31:0] stream_ins [N];

    imm_decode_ctrl_if #(.PC_WIDTH(32)) bus ();

    imm_decode_ctrl #(
        .PC_WIDTH     (32),
        .CUSTOM_OPCODE(7'b0001011)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .FLUSH(FLUSH),
        .bus  (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic item_t model(input logic [31:0] ins, input logic [31:0] pc);
        item_t it;
        it.instr = ins;
        it.pc    = pc;
        it.sel   = 4'h0;
        it.en    = 1'b0;
        it.ill   = 1'b0;
        case (ins[6:0])
            7'h37, 7'h17: it.en = 1'b1;
            7'h6F: begin it.sel = 4'h1; it.en = 1'b1; end
            7'h67, 7'h03: begin it.sel = 4'h2; it.en = 1'b1; end
            7'h13: begin
                it.sel = (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) ? 4'h5 : 4'h2;
                it.en  = 1'b1;
            end
            7'h63: begin it.sel = 4'h3; it.en = 1'b1; end
            7'h23: begin it.sel = 4'h4; it.en = 1'b1; end
            7'h0B: begin it.sel = 4'hA; it.en = 1'b1; end
            7'h33, 7'h0F, 7'h73: ;
            default: it.ill = 1'b1;
        endcase
        return it;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        FLUSH = 1'b0;
        bus.IN_VALID = 1'b0;
        bus.OUT_READY = 1'b0;
        bus.INSTRUCTION = 32'h0;
        bus.PC = 32'h0;
        repeat (2) tick();
        RESET = 1'b0;
        @(negedge CLK);
        checks++;
        if (bus.IN_READY !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.IN_READY);
        end
        checks++;
        if ({bus.OUT_VALID, bus.OUT_INSTRUCTION, bus.OUT_PC, bus.IMM_SEL, bus.IMM_EN,
             bus.ILLEGAL} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b i=%h pc=%h sel=%b en=%b ill=%b expected 0",
                     bus.OUT_VALID, bus.OUT_INSTRUCTION, bus.OUT_PC, bus.IMM_SEL, bus.IMM_EN,
                     bus.ILLEGAL);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        item_t got, exp;
        bus.OUT_READY = 1'b1;
        for (int c = 0; c < N + 4; c++) begin
            if (c < N) begin
                bus.IN_VALID = 1'b1;
                bus.INSTRUCTION = stream_ins[c];
                bus.PC = 32'h1000 + 32'(4 * c);
            end else begin
                bus.IN_VALID = 1'b0;
            end
            @(negedge CLK);
            if (c == 0) begin
                checks++;
                if (bus.OUT_VALID !== 1'b0) begin
                    errors++; $display("FAIL b2b_latency: got OUT_VALID=%b expected 0",
                                       bus.OUT_VALID);
                end
            end
            if (c >= 1 && c <= N) begin
                checks++;
                if (bus.OUT_VALID !== 1'b1) begin
                    errors++; $display("FAIL b2b_bubble cycle %0d: got OUT_VALID=%b expected 1",
                                       c, bus.OUT_VALID);
                end
            end
            if (c == 1) begin
                checks++;
                if ({bus.IMM_SEL, bus.IMM_EN} !== 5'b0000_1) begin
                    errors++; $display("FAIL b2b_lui: got sel=%b en=%b expected 0000 1",
                                       bus.IMM_SEL, bus.IMM_EN);
                end
            end
            if (bus.OUT_VALID && bus.OUT_READY) begin
                got = {bus.OUT_INSTRUCTION, bus.OUT_PC, bus.IMM_SEL, bus.IMM_EN, bus.ILLEGAL};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_sb_extra: got %h expected nothing", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        errors++; $display("FAIL b2b_sb: got %h expected %h", got, exp);
                    end
                end
            end
            if (bus.IN_VALID && bus.IN_READY) exp_q.push_back(model(bus.INSTRUCTION, bus.PC));
            tick();
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL b2b_drain: got %0d left expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_backpressure();
        bus.OUT_READY = 1'b0;
        bus.IN_VALID = 1'b1;
        bus.INSTRUCTION = 32'h00500093;
        bus.PC = 32'h2000;
        @(negedge CLK);
        checks++;
        if (bus.IN_READY !== 1'b1) begin
            errors++; $display("FAIL bp_ready0: got %b expected 1", bus.IN_READY);
        end
        tick();
        bus.INSTRUCTION = 32'h00208463;
        bus.PC = 32'h2004;
        @(negedge CLK);
        checks++;
        if (bus.IN_READY !== 1'b1 || bus.OUT_INSTRUCTION !== 32'h00500093) begin
            errors++; $display("FAIL bp_one: got rdy=%b ins=%h expected 1 00500093",
                               bus.IN_READY, bus.OUT_INSTRUCTION);
        end
        tick();
        bus.IN_VALID = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            checks++;
            if (bus.IN_READY !== 1'b0 || bus.OUT_INSTRUCTION !== 32'h00500093 ||
                bus.IMM_SEL !== 4'b0010) begin
                errors++; $display("FAIL bp_full: got rdy=%b ins=%h sel=%b expected 0 00500093 0010",
                                   bus.IN_READY, bus.OUT_INSTRUCTION, bus.IMM_SEL);
            end
            tick();
        end
        bus.OUT_READY = 1'b1;
        @(negedge CLK);
        checks++;
        if (bus.OUT_INSTRUCTION !== 32'h00500093 || bus.OUT_PC !== 32'h2000) begin
            errors++; $display("FAIL bp_first: got %h@%h expected 00500093@2000",
                               bus.OUT_INSTRUCTION, bus.OUT_PC);
        end
        tick();
        @(negedge CLK);
        checks++;
        if (bus.OUT_INSTRUCTION !== 32'h00208463 || bus.IMM_SEL !== 4'b0011 ||
            bus.IN_READY !== 1'b1) begin
            errors++; $display("FAIL bp_second: got ins=%h sel=%b rdy=%b expected 00208463 0011 1",
                               bus.OUT_INSTRUCTION, bus.IMM_SEL, bus.IN_READY);
        end
        tick();
        @(negedge CLK);
        checks++;
        if (bus.OUT_VALID !== 1'b0) begin
            errors++; $display("FAIL bp_empty: got %b expected 0", bus.OUT_VALID);
        end
        tick();
    endtask

    task automatic test_decode();
        logic [31:0] ins [6];
        logic [5:0]  want [6];
        ins[0] = 32'h00209093; want[0] = 6'b0101_1_0;
        ins[1] = 32'h00112223; want[1] = 6'b0100_1_0;
        ins[2] = 32'h008000EF; want[2] = 6'b0001_1_0;
        ins[3] = 32'h0000000B; want[3] = 6'b1010_1_0;
        ins[4] = 32'h002081B3; want[4] = 6'b0000_0_0;
        ins[5] = 32'h0000007F; want[5] = 6'b0000_0_1;
        bus.OUT_READY = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.IN_VALID = 1'b1;
            bus.INSTRUCTION = ins[k];
            bus.PC = 32'h3000 + 32'(4 * k);
            tick();
            bus.IN_VALID = 1'b0;
            @(negedge CLK);
            checks++;
            if (bus.OUT_VALID !== 1'b1 || bus.OUT_INSTRUCTION !== ins[k] ||
                {bus.IMM_SEL, bus.IMM_EN, bus.ILLEGAL} !== want[k]) begin
                errors++;
                $display("FAIL decode %h: got v=%b ins=%h sel/en/ill=%b expected 1 %h %b",
                         ins[k], bus.OUT_VALID, bus.OUT_INSTRUCTION,
                         {bus.IMM_SEL, bus.IMM_EN, bus.ILLEGAL}, ins[k], want[k]);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        bus.OUT_READY = 1'b0;
        bus.IN_VALID = 1'b1;
        bus.INSTRUCTION = 32'h00500093; bus.PC = 32'h4000; tick();
        bus.INSTRUCTION = 32'h00208463; bus.PC = 32'h4004; tick();
        bus.INSTRUCTION = 32'h00112223; bus.PC = 32'h4008;
        FLUSH = 1'b1;
        @(negedge CLK);
        checks++;
        if (bus.IN_READY !== 1'b0) begin
            errors++; $display("FAIL flush_full: got IN_READY=%b expected 0", bus.IN_READY);
        end
        tick();
        FLUSH = 1'b0;
        bus.IN_VALID = 1'b0;
        @(negedge CLK);
        checks++;
        if (bus.OUT_VALID !== 1'b0 || bus.IN_READY !== 1'b1 || bus.OUT_INSTRUCTION !== 32'h0) begin
            errors++; $display("FAIL flush_after: got v=%b rdy=%b ins=%h expected 0 1 0",
                               bus.OUT_VALID, bus.IN_READY, bus.OUT_INSTRUCTION);
        end
        tick();
        bus.OUT_READY = 1'b1;
        bus.IN_VALID = 1'b1;
        bus.INSTRUCTION = 32'h008000EF; bus.PC = 32'h5000;
        tick();
        bus.IN_VALID = 1'b0;
        @(negedge CLK);
        checks++;
        if (bus.OUT_VALID !== 1'b1 || bus.OUT_INSTRUCTION !== 32'h008000EF) begin
            errors++; $display("FAIL flush_next: got v=%b ins=%h expected 1 008000ef",
                               bus.OUT_VALID, bus.OUT_INSTRUCTION);
        end
        tick();
        @(negedge CLK);
        checks++;
        if (bus.OUT_VALID !== 1'b0) begin
            errors++; $display("FAIL flush_stale: got OUT_VALID=%b ins=%h expected 0",
                               bus.OUT_VALID, bus.OUT_INSTRUCTION);
        end
        tick();
    endtask

    task automatic test_reset_midstream();
        bus.OUT_READY = 1'b0;
        bus.IN_VALID = 1'b1;
        bus.INSTRUCTION = 32'h0000000B; bus.PC = 32'h6000; tick();
        bus.INSTRUCTION = 32'h00209093; bus.PC = 32'h6004; tick();
        RESET = 1'b1;
        FLUSH = 1'b1;
        bus.INSTRUCTION = 32'h000120B7; bus.PC = 32'h6008;
        tick();
        RESET = 1'b0;
        FLUSH = 1'b0;
        bus.IN_VALID = 1'b0;
        @(negedge CLK);
        checks++;
        if (bus.OUT_VALID !== 1'b0 || bus.IN_READY !== 1'b1) begin
            errors++; $display("FAIL rst_mid_hs: got v=%b rdy=%b expected 0 1",
                               bus.OUT_VALID, bus.IN_READY);
        end
        checks++;
        if ({bus.OUT_INSTRUCTION, bus.OUT_PC, bus.IMM_SEL, bus.IMM_EN, bus.ILLEGAL} !== '0) begin
            errors++; $display("FAIL rst_mid_out: got ins=%h pc=%h sel=%b en=%b ill=%b expected 0",
                               bus.OUT_INSTRUCTION, bus.OUT_PC, bus.IMM_SEL, bus.IMM_EN,
                               bus.ILLEGAL);
        end
        tick();
    endtask

    task automatic test_random();
        item_t       got, exp;
        logic [31:0] pc_cnt;
        int          pops;
        pc_cnt = 32'h8000;
        pops = 0;
        for (int c = 0; c < 10000 + 6; c++) begin
            if (c < 10000) begin
                bus.IN_VALID = ($urandom_range(0, 9) < 6);
                bus.OUT_READY = ($urandom_range(0, 9) < 5);
                bus.INSTRUCTION = stream_ins[$urandom_range(0, N - 1)] ^
                                  ($urandom & 32'hFFFF_8F80);
                bus.PC = pc_cnt;
            end else begin
                bus.IN_VALID = 1'b0;
                bus.OUT_READY = 1'b1;
            end
            @(negedge CLK);
            if (bus.OUT_VALID && bus.OUT_READY) begin
                got = {bus.OUT_INSTRUCTION, bus.OUT_PC, bus.IMM_SEL, bus.IMM_EN, bus.ILLEGAL};
                pops++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_dup: got %h expected nothing", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        errors++; $display("FAIL rand_sb: got %h expected %h", got, exp);
                    end
                end
            end
            if (bus.IN_VALID && bus.IN_READY) begin
                exp_q.push_back(model(bus.INSTRUCTION, bus.PC));
                pc_cnt = pc_cnt + 32'd4;
            end
            tick();
        end
        checks++;
        if (exp_q.size() != 0 || pops < 1000) begin
            errors++; $display("FAIL rand_loss: got %0d left, %0d pops expected 0 left, >=1000",
                               exp_q.size(), pops);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        stream_ins[0]  = 32'h000120B7;
        stream_ins[1]  = 32'h00500093;
        stream_ins[2]  = 32'h00208463;
        stream_ins[3]  = 32'h00209093;
        stream_ins[4]  = 32'h00112223;
        stream_ins[5]  = 32'h008000EF;
        stream_ins[6]  = 32'h0000000B;
        stream_ins[7]  = 32'h002081B3;
        stream_ins[8]  = 32'h0000007F;
        stream_ins[9]  = 32'h0000A103;
        stream_ins[10] = 32'h4010D093;
        stream_ins[11] = 32'h00000073;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_decode();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
